dsc_mul_op_sequencer: RTL and testbench
=======================================

DSC_MUL_OP_SEQUENCER -- requirements
Module: dsc_mul_op_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, giving the width of each operand.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, giving the operand count (2..5).
REQ-003 SHALL have parameter CLR_CYCLES, default 2, giving the multiplier clear pulse length in cycles (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 2**(DATA_WIDTH*NUM_INPUTS), giving the maximum number of RUN cycles before abort.
REQ-005 SHALL have localparam PW = DATA_WIDTH*NUM_INPUTS, the product width.
REQ-006 clk  in  1  the single clock; all logic rising-edge.
REQ-007 rst  in  1  reset; synchronous, active-low.
REQ-008 in_valid  in  1  operand set offered.
REQ-009 in_ready  out  1  sequencer can accept an operand set.
REQ-010 in_data  in  PW  packed operands; operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 mul_rst  out  1  active-high clear to the stochastic multiplier.
REQ-012 mul_en  out  1  enable to the multiplier's SNGs.
REQ-013 mul_bin_in  out  PW  registered operands driven to the multiplier.
REQ-014 mul_done  in  1  multiplier completion flag.
REQ-015 mul_result  in  PW  multiplier accumulator count.
REQ-016 out_valid  out  1  result available.
REQ-017 out_ready  in  1  consumer accepts the result.
REQ-018 out_data  out  PW  captured product.
REQ-019 out_timeout  out  1  result is an aborted partial count; qualified by out_valid.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, CLR, RUN, DRAIN and HOLD.
REQ-022 IDLE: in_ready=1; when in_valid=1, SHALL register in_data into mul_bin_in.
REQ-023 IDLE accept with any operand equal to 0: SHALL go to HOLD with out_data=0 and out_timeout=0, without launching the multiplier; out_valid is high the next cycle.
REQ-024 IDLE accept with all operands nonzero: SHALL go to CLR.
REQ-025 CLR: mul_rst=1 and mul_en=0 for exactly CLR_CYCLES cycles, using a counter, then SHALL go to RUN.
REQ-026 RUN: mul_en=1 and the cycle counter increments once per cycle, starting from 0.
REQ-027 RUN: mul_done SHALL be ignored during the first 2 RUN cycles, which masks the SNG start-up transient.
REQ-028 RUN, mul_done=1 after the mask: SHALL go to DRAIN.
REQ-029 RUN, counter reaches TIMEOUT-1 without mul_done: SHALL capture mul_result, set out_timeout=1 and go to HOLD.
REQ-030 RUN, mul_done and the timeout in the same cycle: done SHALL win, with out_timeout=0 and a transition to DRAIN.
REQ-031 DRAIN: mul_en=0 for one cycle so the accumulator completes its last add; SHALL then capture mul_result into out_data and go to HOLD.
REQ-032 HOLD: out_valid=1, with out_data and out_timeout held stable until the handshake.
REQ-033 HOLD, out_ready=1: SHALL go to IDLE.
REQ-034 in_ready SHALL NOT be asserted in the same cycle as the HOLD handshake; there is no bypass path.
REQ-035 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored.
REQ-036 Latency: accept in cycle T; RUN spans T+CLR_CYCLES+1 onward; mul_done sampled in cycle D gives DRAIN at D+1 and out_valid at D+2.
REQ-037 The cycle counter SHALL be ceil(log2(TIMEOUT))+1 bits wide and never wrap.
REQ-038 mul_result SHALL be captured unmodified with no scaling.
REQ-039 mul_en and mul_rst SHALL never be high simultaneously.

Reset
REQ-040 While rst=0: state=IDLE; in_ready=0 during reset, then 1 in the first post-reset cycle.
REQ-041 While rst=0: out_valid=0, out_data=0, out_timeout=0, busy=0, mul_en=0, mul_bin_in=0, and all counters 0.
REQ-042 mul_rst SHALL be 1 whenever rst=0, so the multiplier is cleared alongside the sequencer.
REQ-043 Reset asserted in any state, including mid-RUN or in HOLD, SHALL abort the operation; the pending result is discarded and no out_valid is issued.

Verification
REQ-044 DATA_WIDTH=5, NUM_INPUTS=2; behavioural multiplier model asserts mul_done 40 cycles after mul_rst drops, with mul_result=256; in_data={5'd16,5'd16} accepted at T -> mul_rst high at T+1 and T+2, mul_en high from T+3, out_valid at done+2, out_data=256, out_timeout=0.
REQ-045 in_data={5'd0,5'd9} -> mul_rst and mul_en stay 0; out_valid one cycle after accept; out_data=0.
REQ-046 Model never asserts done, TIMEOUT=64 -> out_valid after 64 RUN cycles, out_timeout=1, out_data=model count at abort.
REQ-047 out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0 throughout; handshake then in_ready=1 the following cycle.
REQ-048 rst pulsed low mid-RUN -> next cycle all outputs at reset values, mul_rst=1; a new operand set is then processed correctly.
REQ-049 Model pulses mul_done in the 1st RUN cycle and again at cycle 20 -> the first pulse is ignored; DRAIN is entered after the cycle-20 pulse.

Source files
------------

// File: rtl/dsc_mul_op_sequencer.sv
// Sequencer that launches one stochastic multiplication per accepted operand set.
// It clears the multiplier, runs it until done or a cycle budget expires, then holds the result.
module dsc_mul_op_sequencer #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 2 ** (DATA_WIDTH * NUM_INPUTS),
  localparam int PW        = DATA_WIDTH * NUM_INPUTS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          mul_rst,
  output logic          mul_en,
  output logic [PW-1:0] mul_bin_in,
  input  logic          mul_done,
  input  logic [PW-1:0] mul_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic          out_timeout,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid is never withdrawn and its data never changes until that transfer.

  localparam int CW  = $clog2(TIMEOUT) + 1;
  localparam int CCW = $clog2(CLR_CYCLES) + 1;
  localparam logic [CW-1:0]  RUN_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  MASK_CYCLES = CW'(2);
  localparam logic [CCW-1:0] CLR_LAST    = CCW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t         state;
  logic           in_ready_q;
  logic           mul_rst_q;
  logic           mul_en_q;
  logic [CW-1:0]  run_cnt;
  logic [CCW-1:0] clr_cnt;
  logic           any_zero;

  // A zero operand makes the product zero, so the multiplier is not launched.
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_data[i*DATA_WIDTH +: DATA_WIDTH] == '0) any_zero = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      mul_rst_q   <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_bin_in  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
      run_cnt     <= '0;
      clr_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_bin_in  <= in_data;
            in_ready_q  <= 1'b0;
            out_timeout <= 1'b0;
            if (any_zero) begin
              out_data  <= '0;
              out_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              mul_rst_q <= 1'b1;
              clr_cnt   <= '0;
              state     <= S_CLR;
            end
          end
        end
        S_CLR: begin
          if (clr_cnt == CLR_LAST) begin
            mul_rst_q <= 1'b0;
            mul_en_q  <= 1'b1;
            run_cnt   <= '0;
            state     <= S_RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Done outranks the timeout; the first two cycles mask the SNG start-up glitch.
          if (mul_done && (run_cnt >= MASK_CYCLES)) begin
            mul_en_q <= 1'b0;
            state    <= S_DRAIN;
          end else if (run_cnt == RUN_LAST) begin
            mul_en_q    <= 1'b0;
            out_data    <= mul_result;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= S_HOLD;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          out_data  <= mul_result;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset gates these directly so the multiplier is cleared in the very cycle rst drops.
  assign in_ready  = in_ready_q & rst;
  assign mul_rst   = mul_rst_q | ~rst;
  assign mul_en    = mul_en_q & rst;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dsc_mul_op_sequencer.sv
// Bench for dsc_mul_op_sequencer with a behavioural stochastic-multiplier model
// and a scoreboard of expected {timeout, product} results.
module tb_dsc_mul_op_sequencer;
  localparam int DW   = 5;
  localparam int NI   = 2;
  localparam int PW   = DW * NI;
  localparam int CLRC = 2;
  localparam int TO   = 64;
  localparam int W    = PW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic          mul_rst;
  logic          mul_en;
  logic [PW-1:0] mul_bin_in;
  logic          mul_done;
  logic [PW-1:0] mul_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_data;
  logic          out_timeout;
  logic          busy;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];

  dsc_mul_op_sequencer #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .CLR_CYCLES(CLRC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_bin_in(mul_bin_in), .mul_done(mul_done),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_timeout(out_timeout), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier model: mode 0 done 40 cycles after clear with result 256,
  // mode 1 never done, mode 2 pulses done at 0 and 20; modes 1/2 report the enable count
  int model_mode = 0;
  int mcnt = 0;
  logic [PW-1:0] acc = '0;
  always @(posedge clk) begin
    if (mul_rst) begin
      mcnt <= 0;
      acc  <= '0;
    end else begin
      mcnt <= mcnt + 1;
      if (mul_en) acc <= acc + 1'b1;
    end
  end
  assign mul_done = !mul_rst && ((model_mode == 0 && mcnt == 40) ||
                                 (model_mode == 2 && (mcnt == 0 || mcnt == 20)));
  assign mul_result = (model_mode == 0) ? PW'(256) : acc;

  logic overlap = 1'b0;
  always @(negedge clk) if (mul_en && mul_rst) overlap = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: offers one operand set in IDLE; returns at the falling edge of the cycle after accept
  task automatic send(input logic [PW-1:0] d, input bit push, input bit exp_to,
                      input logic [PW-1:0] exp_data, input int exp_lat);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_in_ready", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    t_acc    = cyc;
    if (push) begin
      exp_q.push_back({exp_to, exp_data});
      lat_q.push_back(exp_lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // monitor: waits for out_valid, compares with the queue head, optionally stalls, then handshakes
  task automatic collect(input string tag, input int stall);
    int waited = 0;
    logic [W-1:0] e;
    int el;
    logic bad;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!out_valid) begin
      check({tag, "_valid"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, cyc - t_acc, el);
    check({tag, "_data"}, out_data, e[PW-1:0]);
    check({tag, "_timeout"}, out_timeout, e[PW]);
    if (stall > 0) begin
      bad = 1'b0;
      in_valid = 1'b1;
      in_data  = PW'($urandom_range(1, 1023));
      repeat (stall) begin
        @(negedge clk);
        if (!out_valid || out_data !== e[PW-1:0] || out_timeout !== e[PW] || in_ready || !busy)
          bad = 1'b1;
      end
      in_valid = 1'b0;
      check({tag, "_hold_stable"}, bad, 0);
    end
    out_ready = 1'b1;
    check({tag, "_no_bypass"}, in_ready, 0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [PW-1:0] d;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_rst", mul_rst, 1);
    check("rst_mul_en", mul_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_bin_in", mul_bin_in, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // normal multiplication, timing of clear and enable
    model_mode = 0;
    send({5'd16, 5'd16}, 1, 0, PW'(256), 45);
    check("a_t1_mul_rst", mul_rst, 1);
    check("a_t1_mul_en", mul_en, 0);
    check("a_t1_bin_in", mul_bin_in, {5'd16, 5'd16});
    check("a_t1_in_ready", in_ready, 0);
    @(negedge clk);
    check("a_t2_mul_rst", mul_rst, 1);
    @(negedge clk);
    check("a_t3_mul_rst", mul_rst, 0);
    check("a_t3_mul_en", mul_en, 1);
    collect("mul_a", 0);

    // zero operand short-cut
    send({5'd0, 5'd9}, 1, 0, PW'(0), 1);
    check("z_mul_rst", mul_rst, 0);
    check("z_mul_en", mul_en, 0);
    collect("zero_a", 0);

    // timeout abort
    model_mode = 1;
    send({5'd3, 5'd7}, 1, 1, PW'(TO - 1), TO + CLRC + 1);
    collect("timeout", 0);

    // early done pulse masked, later pulse honoured
    model_mode = 2;
    send({5'd2, 5'd3}, 1, 0, PW'(21), 25);
    collect("mask", 0);

    // consumer stall in HOLD with new operands offered
    model_mode = 0;
    send({5'd5, 5'd6}, 1, 0, PW'(256), 45);
    collect("stall", 10);

    // reset mid-RUN aborts the operation
    send({5'd16, 5'd16}, 0, 0, '0, 0);
    repeat (10) @(negedge clk);
    check("abort_running", mul_en, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_mul_en", mul_en, 0);
    check("abort_mul_rst", mul_rst, 1);
    check("abort_in_ready", in_ready, 0);
    check("abort_bin_in", mul_bin_in, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    send({5'd16, 5'd16}, 1, 0, PW'(256), 45);
    collect("after_abort", 0);

    // random operand sets with one operand zero
    for (int i = 0; i < 4; i++) begin
      d = '0;
      d[DW-1:0]  = DW'($urandom_range(1, 31));
      d[PW-1:DW] = DW'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 0) d[DW-1:0] = '0;
      else d[PW-1:DW] = '0;
      send(d, 1, 0, PW'(0), 1);
      collect("zero_rand", 0);
    end

    // random nonzero operand sets
    for (int i = 0; i < 2; i++) begin
      d = {DW'($urandom_range(1, 31)), DW'($urandom_range(1, 31))};
      send(d, 1, 0, PW'(256), 45);
      collect("mul_rand", 0);
    end

    check("en_rst_exclusive", overlap, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
